// File: rtl/bpsk_pkg.sv
// Shared BPSK receiver definitions: 12.20 sample format, saturation limits and the
// integrate-and-dump state encoding.
package bpsk_pkg;

    localparam int unsigned FRAC_W = 20;
    localparam int unsigned INT_W  = 12;
    localparam int unsigned DATA_W = INT_W + FRAC_W;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/sat_trunc.sv
// Combinational signed saturator from IN_W to OUT_W bits; ovf_o flags a clipped value.
module sat_trunc #(
    parameter int unsigned IN_W  = 40,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  din_i,
    output logic [OUT_W-1:0] dout_o,
    output logic             ovf_o
);

    localparam int unsigned TOP_W = IN_W - OUT_W + 1;

    logic [TOP_W-1:0] top_bits;

    // Value fits only if every bit from the output sign bit upward agrees.
    always_comb begin
        top_bits = din_i[IN_W-1:OUT_W-1];
        ovf_o    = !((&top_bits) || !(|top_bits));
        if (!ovf_o) begin
            dout_o = din_i[OUT_W-1:0];
        end else if (din_i[IN_W-1]) begin
            dout_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump matched filter: sums SPB valid 12.20 samples per symbol and dumps a
// saturated symbol sum with a hard bit decision. State advances on the falling clock edge.
module integrate_dump #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned SPB    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_in,
    input  logic [DATA_W-1:0] din,
    input  logic              resync,
    output logic [DATA_W-1:0] dout,
    output logic              bit_out,
    output logic              flag_out,
    output logic              ovf
);

    import bpsk_pkg::*;

    localparam int unsigned CNT_W = (SPB > 2) ? $clog2(SPB) : 1;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              bit_q, bit_d;
    logic              flag_q, flag_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  din_sext;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] sum_sat;
    logic              sum_ovf;
    logic              last_sample;

    assign din_sext    = {{(ACC_W-DATA_W){din[DATA_W-1]}}, din};
    assign sum         = acc_q + din_sext;
    assign last_sample = (cnt_q == CNT_W'(SPB - 1));

    sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat (
        .din_i  (sum),
        .dout_o (sum_sat),
        .ovf_o  (sum_ovf)
    );

    // State and output registers.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bit_q   <= 1'b0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bit_q   <= bit_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state: leave IDLE on the first valid sample; ACCUM is terminal until reset.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && flag_in) begin
            state_d = ACCUM;
        end
    end

    // Datapath and outputs: resync outranks the dump.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        bit_d  = bit_q;
        flag_d = 1'b0;
        ovf_d  = ovf_q;
        if (resync) begin
            acc_d = flag_in ? din_sext : '0;
            cnt_d = flag_in ? CNT_W'(1) : '0;
        end else if (flag_in) begin
            if (state_q == IDLE) begin
                acc_d = din_sext;
                cnt_d = CNT_W'(1);
            end else if (last_sample) begin
                acc_d  = '0;
                cnt_d  = '0;
                dout_d = sum_sat;
                bit_d  = ~sum_sat[DATA_W-1];
                flag_d = 1'b1;
                ovf_d  = ovf_q | sum_ovf;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign dout     = dout_q;
    assign bit_out  = bit_q;
    assign flag_out = flag_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_integrate_dump.sv
// Directed bench for integrate_dump with SPB=4 and hand-computed symbol sums.
module tb_integrate_dump;

    import bpsk_pkg::*;

    localparam logic [31:0] P1  = 32'h0010_0000; // +1.0
    localparam logic [31:0] P2  = 32'h0020_0000; // +2.0
    localparam logic [31:0] M1  = 32'hFFF0_0000; // -1.0
    localparam logic [31:0] MH  = 32'hFFF8_0000; // -0.5

    logic        clk = 1'b0;
    logic        reset;
    logic        flag_in;
    logic [31:0] din;
    logic        resync;
    logic [31:0] dout;
    logic        bit_out;
    logic        flag_out;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    integrate_dump #(.DATA_W(32), .ACC_W(40), .SPB(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .flag_in  (flag_in),
        .din      (din),
        .resync   (resync),
        .dout     (dout),
        .bit_out  (bit_out),
        .flag_out (flag_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Apply one cycle of inputs, wait past the falling edge, check flag_out.
    task automatic step(input logic rs, input logic f, input logic [31:0] d,
                        input logic rsy, input logic exp_flag, input string tag);
        reset   = rs;
        flag_in = f;
        din     = d;
        resync  = rsy;
        @(negedge clk);
        #1;
        check(tag, 32'(flag_out), 32'(exp_flag));
    endtask

    task automatic symbol(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3, input string tag);
        step(0, 1, d0, 0, 0, {tag, ".f1"});
        step(0, 1, d1, 0, 0, {tag, ".f2"});
        step(0, 1, d2, 0, 0, {tag, ".f3"});
        step(0, 1, d3, 0, 1, {tag, ".f4"});
    endtask

    task automatic outs(input logic [31:0] e_dout, input logic e_bit, input logic e_ovf,
                        input string tag);
        check({tag, ".dout"}, dout, e_dout);
        check({tag, ".bit"},  32'(bit_out), 32'(e_bit));
        check({tag, ".ovf"},  32'(ovf), 32'(e_ovf));
    endtask

    initial begin
        reset = 1'b1; flag_in = 1'b0; din = '0; resync = 1'b0;
        #1;
        step(1, 1, P1, 0, 0, "rst0");
        step(1, 1, P1, 0, 0, "rst1");
        outs(32'h0, 1'b0, 1'b0, "rst");

        // resync in IDLE without a sample stays idle; boundary sums exactly at the limits
        step(0, 0, '0, 1, 0, "idle_rsy");
        symbol(32'h4000_0000, 32'h3FFF_FFFF, 32'h0, 32'h0, "maxexact");
        outs(SAT_MAX, 1'b1, 1'b0, "maxexact");
        symbol(32'hC000_0000, 32'hC000_0000, 32'h0, 32'h0, "minexact");
        outs(SAT_MIN, 1'b0, 1'b0, "minexact");
        symbol(32'h0, 32'h0, 32'h0, 32'h0, "zero");
        outs(32'h0, 1'b1, 1'b0, "zero");

        // +1.0 x4 back-to-back, then dout holds through idle cycles
        symbol(P1, P1, P1, P1, "pos");
        outs(32'h0040_0000, 1'b1, 1'b0, "pos");
        step(0, 0, 32'hDEAD_BEEF, 0, 0, "hold1");
        step(0, 0, '0, 0, 0, "hold2");
        check("hold.dout", dout, 32'h0040_0000);

        // -0.5 x4 with two idle cycles between samples
        for (int i = 0; i < 4; i++) begin
            step(0, 1, MH, 0, (i == 3), "gap.f");
            if (i < 3) begin
                step(0, 0, P1, 0, 0, "gap.g1");
                step(0, 0, P1, 0, 0, "gap.g2");
            end
        end
        outs(32'hFFE0_0000, 1'b0, 1'b0, "gap");

        // positive and negative overflow; ovf sticks across a clean symbol
        symbol(SAT_MAX, SAT_MAX, SAT_MAX, SAT_MAX, "satp");
        outs(32'h7FFF_FFFF, 1'b1, 1'b1, "satp");
        symbol(P1, P1, P1, P1, "after_sat");
        outs(32'h0040_0000, 1'b1, 1'b1, "after_sat");
        symbol(32'hC000_0000, 32'hC000_0000, 32'hFFFF_FFFF, 32'h0, "satn");
        outs(32'h8000_0000, 1'b0, 1'b1, "satn");

        // resync with a +2.0 sample after two +1.0 samples
        step(0, 1, P1, 0, 0, "rsy.a1");
        step(0, 1, P1, 0, 0, "rsy.a2");
        step(0, 1, P2, 1, 0, "rsy.r");
        step(0, 1, P1, 0, 0, "rsy.b1");
        step(0, 1, P1, 0, 0, "rsy.b2");
        step(0, 1, P1, 0, 1, "rsy.b3");
        outs(32'h0050_0000, 1'b1, 1'b1, "rsy");

        // mid-symbol reset discards the partial sum and clears ovf
        step(0, 1, P1, 0, 0, "mrst.a1");
        step(0, 1, P1, 0, 0, "mrst.a2");
        step(0, 1, P1, 0, 0, "mrst.a3");
        step(1, 1, P1, 0, 0, "mrst.r1");
        outs(32'h0, 1'b0, 1'b0, "mrst.r1");
        step(1, 1, P1, 0, 0, "mrst.r2");
        outs(32'h0, 1'b0, 1'b0, "mrst.r2");
        symbol(M1, M1, M1, M1, "mrst.neg");
        outs(32'hFFC0_0000, 1'b0, 1'b0, "mrst.neg");

        // resync on what would be the 4th sample: no dump, sample starts next symbol
        step(0, 1, P1, 0, 0, "rs4.a1");
        step(0, 1, P1, 0, 0, "rs4.a2");
        step(0, 1, P1, 0, 0, "rs4.a3");
        step(0, 1, P2, 1, 0, "rs4.r");
        check("rs4.hold", dout, 32'hFFC0_0000);
        step(0, 1, P1, 0, 0, "rs4.b1");
        step(0, 1, P1, 0, 0, "rs4.b2");
        step(0, 1, M1, 0, 1, "rs4.b3");
        outs(32'h0030_0000, 1'b1, 1'b0, "rs4");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
